// File: rtl/mealy_fsm_bank_pkg.sv
// Shared types and state encodings for the Mealy FSM bank.
// Used by mealy_fsm_chan and mealy_fsm_bank.
package mealy_fsm_bank_pkg;

  typedef logic [1:0] state_t;

  localparam state_t AC = 2'b00;
  localparam state_t BD = 2'b01;
  localparam state_t E  = 2'b10;
  localparam state_t F  = 2'b11;

  // Next state for a valid input bit.
  function automatic state_t next_of(
    input state_t s,
    input logic   xb
  );
    state_t n;
    n = s;
    unique case (s)
      AC:      n = xb ? BD : E;
      BD:      n = xb ? BD : F;
      E:       n = xb ? F  : AC;
      F:       n = xb ? AC : BD;
      default: n = AC;
    endcase
    return n;
  endfunction

  // Mealy output for a valid input bit.
  function automatic logic out_of(
    input state_t s,
    input logic   xb
  );
    logic o;
    o = 1'b0;
    unique case (s)
      AC:      o = xb;
      E:       o = xb;
      default: o = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mealy_fsm_bank_chan.sv
// One Mealy FSM channel: state register, next-state/z logic, hit counter.
// MEALY_FSM_BANK_REG_OUT_EN registers z/z_valid (1-cycle latency).
module mealy_fsm_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             x,
  input  logic             clr_cnt,
  output logic             z,
  output logic             z_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] hit_cnt
);
  import mealy_fsm_bank_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t cur;
  state_t nxt;
  logic   mz;

  // State register; reset discards all history.
  always_ff @(posedge clk) begin
    if (!reset) cur <= AC;
    else        cur <= nxt;
  end

  // Next state: advance only on qualified input.
  always_comb begin
    nxt = cur;
    if (in_valid) nxt = next_of(cur, x);
  end

  // Pre-register Mealy output, zero when unqualified.
  always_comb begin
    mz = 1'b0;
    if (in_valid) mz = out_of(cur, x);
  end

  // Saturating hit counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!reset)                        hit_cnt <= '0;
    else if (clr_cnt)                  hit_cnt <= '0;
    else if (mz && hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + CNT_ONE;
  end

  assign state = cur;

`ifdef MEALY_FSM_BANK_REG_OUT_EN
  // Registered output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      z       <= 1'b0;
      z_valid <= 1'b0;
    end else begin
      z       <= mz;
      z_valid <= in_valid;
    end
  end
`else
  assign z       = mz;
  assign z_valid = in_valid;
`endif

endmodule

// File: rtl/mealy_fsm_bank.sv
// Bank of NCH independent Mealy FSM channels with hit counters.
// MEALY_FSM_BANK_REG_OUT_EN registers z, z_valid and any_hit.
module mealy_fsm_bank #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       x,
  input  logic                 clr_cnt,
  output logic [NCH-1:0]       z,
  output logic [NCH-1:0]       z_valid,
  output logic [2*NCH-1:0]     state_o,
  output logic [NCH*CNT_W-1:0] hit_cnt,
  output logic                 any_hit
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mealy_fsm_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid[i]),
      .x        (x[i]),
      .clr_cnt  (clr_cnt),
      .z        (z[i]),
      .z_valid  (z_valid[i]),
      .state    (state_o[2*i +: 2]),
      .hit_cnt  (hit_cnt[CNT_W*i +: CNT_W])
    );
  end

  // Built from z/z_valid, so it inherits their registration.
  assign any_hit = |(z & z_valid);

endmodule

// File: tb/tb_mealy_fsm_bank.sv
// Directed and scoreboard bench for mealy_fsm_bank (NCH=4, CNT_W=2).
// Works in both the default and MEALY_FSM_BANK_REG_OUT_EN builds.
module tb_mealy_fsm_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_valid = '0;
  logic [3:0] x = '0;
  logic       clr_cnt = 1'b0;
  logic [3:0] z;
  logic [3:0] z_valid;
  logic [7:0] state_o;
  logic [7:0] hit_cnt;
  logic       any_hit;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mealy_fsm_bank #(
    .NCH   (4),
    .CNT_W (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .x        (x),
    .clr_cnt  (clr_cnt),
    .z        (z),
    .z_valid  (z_valid),
    .state_o  (state_o),
    .hit_cnt  (hit_cnt),
    .any_hit  (any_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ez,
                         input logic [3:0] ezv);
    chk({tag, ".z"}, {28'd0, z}, {28'd0, ez});
    chk({tag, ".zv"}, {28'd0, z_valid}, {28'd0, ezv});
    chk({tag, ".any"}, {31'd0, any_hit}, {31'd0, |(ez & ezv)});
  endtask

  // One clock: drive at negedge, check z where each build shows it.
  task automatic cycle(input string tag, input logic rst,
                       input logic [3:0] iv, input logic [3:0] xv,
                       input logic clr, input logic do_z,
                       input logic [3:0] ez, input logic [3:0] ezv);
    @(negedge clk);
    reset = rst;
    in_valid = iv;
    x = xv;
    clr_cnt = clr;
`ifndef MEALY_FSM_BANK_REG_OUT_EN
    #1;
    if (do_z) chk_out(tag, ez, ezv);
`endif
    @(posedge clk);
    #1;
`ifdef MEALY_FSM_BANK_REG_OUT_EN
    if (do_z) chk_out(tag, ez, ezv);
`endif
  endtask

  // Reference transition table: {next_state, z}.
  function automatic logic [2:0] mdl(input logic [1:0] s, input logic xb);
    case (s)
      2'b00:   return xb ? 3'b01_1 : 3'b10_0;
      2'b01:   return xb ? 3'b01_0 : 3'b11_0;
      2'b10:   return xb ? 3'b11_1 : 3'b00_0;
      default: return xb ? 3'b00_0 : 3'b01_0;
    endcase
  endfunction

  logic [1:0] st28 [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic       x28  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       z28  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic       x30  [15] = '{1,1,1,0,1,0,1,1,1,0,1,1, 0,1,1};
  logic       c30  [15] = '{0,0,0,0,0,0,0,0,0,0,0,0, 0,0,1};
  logic       z30  [15] = '{1,0,0,0,0,0,1,0,1,0,0,1, 0,0,1};
  logic [1:0] st30 [15] = '{1,1,1,3,0,2,3,0,1,3,0,1, 3,0,1};
  logic [1:0] h30  [15] = '{1,1,1,1,1,1,2,2,3,3,3,3, 3,3,0};

  logic [1:0] ms [4];
  logic [1:0] mh [4];

  initial begin
    logic [3:0] iv, xv, ez;
    logic [7:0] est, ehc;
    logic [2:0] r;

    // Reset held two cycles with activity on the inputs.
    cycle("rst0", 1'b0, 4'hf, 4'hf, 1'b1, 1'b0, 4'h0, 4'h0);
    cycle("rst1", 1'b0, 4'hf, 4'hf, 1'b1, 1'b0, 4'h0, 4'h0);
    cycle("rel", 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0);
    chk("rst.state", {24'd0, state_o}, 32'd0);
    chk("rst.hit", {24'd0, hit_cnt}, 32'd0);

    // Channel 0: x = 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      cycle("seq28", 1'b1, 4'b0001, {3'b0, x28[k]}, 1'b0, 1'b1,
            {3'b0, z28[k]}, 4'b0001);
      chk("seq28.st", {30'd0, state_o[1:0]}, {30'd0, st28[k]});
    end
    chk("seq28.hit", {30'd0, hit_cnt[1:0]}, 32'd1);
    chk("seq28.others", {26'd0, state_o[7:2]}, 32'd0);

    // Restart from AC, then x = 0,1.
    cycle("rst29", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    cycle("seq29a", 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 4'h0, 4'b0001);
    chk("seq29a.st", {30'd0, state_o[1:0]}, 32'd2);
    cycle("seq29b", 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0001);
    chk("seq29b.st", {30'd0, state_o[1:0]}, 32'd3);
    chk("seq29.hit", {30'd0, hit_cnt[1:0]}, 32'd1);

    // Reset while in F with x=1 lands in AC, not via F->AC.
    cycle("rst32", 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'h0, 4'h0);
    chk("rst32.st", {30'd0, state_o[1:0]}, 32'd0);
    chk("rst32.hit", {30'd0, hit_cnt[1:0]}, 32'd0);
    cycle("post32", 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0001);
    chk("post32.st", {30'd0, state_o[1:0]}, 32'd1);
    chk("post32.hit", {30'd0, hit_cnt[1:0]}, 32'd1);

    // Channel 1: saturation at 3, then clear on a hit cycle.
    for (int k = 0; k < 15; k++) begin
      cycle("sat30", 1'b1, 4'b0010, {2'b0, x30[k], 1'b0}, c30[k], 1'b1,
            {2'b0, z30[k], 1'b0}, 4'b0010);
      chk("sat30.st", {30'd0, state_o[3:2]}, {30'd0, st30[k]});
      chk("sat30.hit", {30'd0, hit_cnt[3:2]}, {30'd0, h30[k]});
    end
    chk("sat30.ch0", {30'd0, state_o[1:0]}, 32'd1);

    // Random streams against the reference table.
    cycle("rst31", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0);
    for (int c = 0; c < 4; c++) begin
      ms[c] = 2'b00;
      mh[c] = 2'b00;
    end
    for (int n = 0; n < 40; n++) begin
      iv = 4'($urandom);
      xv = 4'($urandom);
      ez = '0;
      for (int c = 0; c < 4; c++) begin
        r = mdl(ms[c], xv[c]);
        if (iv[c]) begin
          ez[c] = r[0];
          ms[c] = r[2:1];
          if (r[0] && mh[c] != 2'd3) mh[c] = mh[c] + 2'd1;
        end
      end
      cycle("rnd", 1'b1, iv, xv, 1'b0, 1'b1, ez, iv);
      for (int c = 0; c < 4; c++) begin
        est[2*c +: 2] = ms[c];
        ehc[2*c +: 2] = mh[c];
      end
      chk("rnd.st", {24'd0, state_o}, {24'd0, est});
      chk("rnd.hit", {24'd0, hit_cnt}, {24'd0, ehc});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mealy_fsm_bank.md
MEALY_FSM_BANK -- requirements
Module: mealy_fsm_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of independent FSM channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of each per-channel hit counter (2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port in_valid  input  NCH  per-channel qualifier for x.
REQ-006 SHALL have port x  input  NCH  per-channel serial input bit.
REQ-007 SHALL have port clr_cnt  input  1  synchronous clear of all hit counters.
REQ-008 SHALL have port z  output  NCH  per-channel Mealy output.
REQ-009 SHALL have port z_valid  output  NCH  per-channel marker that z is meaningful this cycle.
REQ-010 SHALL have port state_o  output  2*NCH  per-channel current state, channel i at [2i+1:2i].
REQ-011 SHALL have port hit_cnt  output  NCH*CNT_W  per-channel saturating count of z=1 events, channel i at [CNT_W*i +: CNT_W].
REQ-012 SHALL have port any_hit  output  1  OR-reduction of (z & z_valid).

Function
REQ-013 Each channel SHALL run a 4-state machine with encodings AC=2'b00, BD=2'b01, E=2'b10, F=2'b11.
REQ-014 Transitions (x=1 / x=0) SHALL be: AC->BD,z=1 / AC->E,z=0; BD->BD,z=0 / BD->F,z=0; E->F,z=1 / E->AC,z=0; F->AC,z=0 / F->BD,z=0.
REQ-015 A channel SHALL advance state only in cycles with in_valid[i]=1; with in_valid[i]=0 it SHALL hold its state, and z[i] and z_valid[i] SHALL be 0.
REQ-016 Channels SHALL be fully independent; no channel's input affects another's state, z or counter.
REQ-017 hit_cnt[i] SHALL increment by 1 in each cycle where the pre-register Mealy output is 1 with in_valid[i]=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-018 clr_cnt=1 SHALL zero every counter on the next edge; clear SHALL take priority over a simultaneous increment, and FSM state SHALL be unaffected.
REQ-019 All state encodings are legal; no illegal-state recovery logic is required.

Reset
REQ-020 On a clk edge with reset=0, every channel SHALL go to AC, every hit_cnt to 0, and z, z_valid and any_hit (when registered) to 0.
REQ-021 Reset SHALL override in_valid and clr_cnt in the same cycle; assertion mid-sequence SHALL discard channel history, and the first valid cycle after release SHALL be evaluated from AC.

Configuration
REQ-022 With macro MEALY_FSM_BANK_REG_OUT_EN defined, z, z_valid and any_hit SHALL be registered, giving 1-cycle latency from in_valid/x to outputs, with reset value 0.
REQ-023 Without MEALY_FSM_BANK_REG_OUT_EN, z, z_valid and any_hit SHALL be combinational from the current state, x and in_valid (zero latency).
REQ-024 In both configurations, state_o and hit_cnt SHALL be registered with identical timing.

Structure
REQ-025 Shared package mealy_fsm_bank_pkg SHALL hold the 2-bit state typedef and the AC/BD/E/F localparams.
REQ-026 A single-channel sub-module mealy_fsm_chan (state register, next-state/z logic, counter) SHALL be instantiated NCH times by generate.

Verification
REQ-027 Reset=0 for 2 cycles, then reset=1 with in_valid=0 -> all state_o=00, hit_cnt=0, z=0.
REQ-028 Channel 0 gets x sequence 1,0,1,0 with in_valid=1 -> states AC->BD->F->AC->E, z=1,0,0,0, hit_cnt[0]=1.
REQ-029 Channel 0 gets x sequence 0,1 with in_valid=1 -> states AC->E->F, z=0,1; in the unregistered build z rises in the same cycle as x=1, and in the REG_OUT build one cycle later.
REQ-030 CNT_W=2, with a channel repeating x=1,1,1 (AC->BD then BD hold) interleaved with 0,1 to force repeated hits -> hit_cnt stops at 3; clr_cnt pulsed on a hit cycle -> counter reads 0.
REQ-031 NCH=4 with distinct random streams and in_valid toggling per channel -> per-channel results match the scoreboard model, and held channels keep state_o unchanged.
REQ-032 reset asserted while a channel is in F with x=1 -> next state is AC (not the F->AC transition path), hit_cnt=0, and a subsequent x=1 gives z=1.
